// File: rtl/fc_pkg.sv
// fc_pkg: shared types and widths for the fully connected layer scheduler
package fc_pkg;
    localparam int N_IN_DEF  = 128;
    localparam int N_OUT_DEF = 10;
    localparam int ACC_W     = 32;
    localparam int ACT_W     = 32;
    localparam int WGT_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } sched_state_t;
endpackage

// File: rtl/fc_mac.sv
// fc_mac: shared multiply-accumulate with bias load and one-cycle response alignment
module fc_mac
    import fc_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    fire,
    input  logic signed [ACC_W-1:0] bias_data,
    input  logic signed [ACT_W-1:0] act_data,
    input  logic signed [WGT_W-1:0] wgt_data,
    output logic signed [ACC_W-1:0] acc
);
    logic                    vld_q;
    logic                    ld_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] wgt_ext;
    logic signed [ACC_W-1:0] prod;

    // Only the low 32 bits of the product survive, so a 32x32 multiply of the sign-extended weight is exact
    always_comb begin
        wgt_ext = {{(ACC_W-WGT_W){wgt_data[WGT_W-1]}}, wgt_data};
        prod    = act_data * wgt_ext;
        acc_d   = ld_q ? bias_data : vld_q ? acc_q + prod : acc_q;
    end

    // Memory data lands one cycle after the strobe, so both strobes are delayed to line up with it
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= 1'b0;
            ld_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            vld_q <= fire;
            ld_q  <= load;
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/fc_layer_sched.sv
// fc_layer_sched: time-multiplexed FC layer scheduler; define FC_SCHED_ARGMAX_EN to add class_idx/class_vld argmax outputs
module fc_layer_sched
    import fc_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int W_AW  = 11,
    localparam int IW   = $clog2(N_IN),
    localparam int OW   = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_req,
    input  logic                    rd_gnt,
    output logic [IW-1:0]           act_addr,
    output logic [W_AW-1:0]         wgt_addr,
    input  logic signed [ACT_W-1:0] act_data,
    input  logic signed [WGT_W-1:0] wgt_data,
    output logic                    bias_rd,
    output logic [OW-1:0]           bias_addr,
    input  logic signed [ACC_W-1:0] bias_data,
    output logic                    out_we,
    output logic [OW-1:0]           out_addr,
    output logic signed [ACC_W-1:0] out_data
`ifdef FC_SCHED_ARGMAX_EN
    ,
    output logic [OW-1:0]           class_idx,
    output logic                    class_vld
`endif
);
    sched_state_t          state_q, state_d;
    logic [OW-1:0]         ind_q, ind_d;
    logic [IW-1:0]         i_q, i_d;
    logic                  busy_q, done_q, rd_req_q, bias_rd_q, out_we_q;
    logic [IW-1:0]         act_addr_q;
    logic [W_AW-1:0]       wgt_addr_q;
    logic                  fire;
    logic signed [ACC_W-1:0] acc;

    assign fire = rd_req_q && rd_gnt;

    // Next-state logic: neuron index advances on WRITE, input index only on granted reads
    always_comb begin
        state_d = state_q;
        ind_d   = ind_q;
        i_d     = i_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BIAS;
                    ind_d   = '0;
                end
            end
            BIAS: begin
                i_d     = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (fire) begin
                    if (i_q == IW'(N_IN - 1)) state_d = DRAIN;
                    else i_d = i_q + IW'(1);
                end
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                if (ind_q == OW'(N_OUT - 1)) begin
                    state_d = DONE;
                end else begin
                    ind_d   = ind_q + OW'(1);
                    state_d = BIAS;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, indices and strobes registered together so every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ind_q      <= '0;
            i_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            bias_rd_q  <= 1'b0;
            out_we_q   <= 1'b0;
            act_addr_q <= '0;
            wgt_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ind_q      <= ind_d;
            i_q        <= i_d;
            busy_q     <= state_d != IDLE;
            done_q     <= state_d == DONE;
            rd_req_q   <= state_d == ISSUE;
            bias_rd_q  <= state_d == BIAS;
            out_we_q   <= state_d == WRITE;
            act_addr_q <= i_d;
            wgt_addr_q <= W_AW'(ind_d) * W_AW'(N_IN) + W_AW'(i_d);
        end
    end

    fc_mac u_mac (
        .clk      (clk),
        .reset    (reset),
        .load     (bias_rd_q),
        .fire     (fire),
        .bias_data(bias_data),
        .act_data (act_data),
        .wgt_data (wgt_data),
        .acc      (acc)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_req    = rd_req_q;
    assign bias_rd   = bias_rd_q;
    assign out_we    = out_we_q;
    assign act_addr  = act_addr_q;
    assign wgt_addr  = wgt_addr_q;
    assign bias_addr = ind_q;
    assign out_addr  = ind_q;
    assign out_data  = acc;

`ifdef FC_SCHED_ARGMAX_EN
    logic signed [ACC_W-1:0] max_q, max_d;
    logic [OW-1:0]           best_q, best_d;
    logic [OW-1:0]           class_idx_q;
    logic                    class_vld_q;
    logic                    upd;

    // Strict greater-than keeps the lowest index on ties; neuron 0 always seeds the running max
    always_comb begin
        upd    = state_q == WRITE && (ind_q == '0 || acc > max_q);
        max_d  = upd ? acc : max_q;
        best_d = upd ? ind_q : best_q;
    end

    // Result is published on entry to DONE and invalidated by the next accepted start
    always_ff @(posedge clk) begin
        if (!reset) begin
            max_q       <= '0;
            best_q      <= '0;
            class_idx_q <= '0;
            class_vld_q <= 1'b0;
        end else begin
            max_q       <= max_d;
            best_q      <= best_d;
            class_idx_q <= state_d == DONE ? best_d : class_idx_q;
            class_vld_q <= state_d == DONE ? 1'b1 : (state_q == IDLE && start) ? 1'b0 : class_vld_q;
        end
    end

    assign class_idx = class_idx_q;
    assign class_vld = class_vld_q;
`endif
endmodule

// File: tb/tb_fc_layer_sched.sv
// tb_fc_layer_sched: directed self-checking bench for fc_layer_sched
module tb_fc_layer_sched;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               rd_gnt = 1'b0;
    logic               busy, done, rd_req, bias_rd, out_we;
    logic [6:0]         act_addr;
    logic [10:0]        wgt_addr;
    logic [3:0]         bias_addr, out_addr;
    logic signed [31:0] act_data = '0;
    logic signed [7:0]  wgt_data = '0;
    logic signed [31:0] bias_data = '0;
    logic signed [31:0] out_data;
`ifdef FC_SCHED_ARGMAX_EN
    logic [3:0]         class_idx;
    logic               class_vld;
`endif

    logic signed [31:0] act_mem [128];
    logic signed [7:0]  wgt_mem [1280];
    logic signed [31:0] bias_mem [10];

    int checks = 0, passed = 0, fails = 0;
    int cyc, we_cnt, done_cnt, stall_cnt, stall_err, done_cyc;
    logic [31:0] cap [10];
    int we_cyc [10];
    int w_we, w_dn;

    fc_layer_sched dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_req   (rd_req),
        .rd_gnt   (rd_gnt),
        .act_addr (act_addr),
        .wgt_addr (wgt_addr),
        .act_data (act_data),
        .wgt_data (wgt_data),
        .bias_rd  (bias_rd),
        .bias_addr(bias_addr),
        .bias_data(bias_data),
        .out_we   (out_we),
        .out_addr (out_addr),
        .out_data (out_data)
`ifdef FC_SCHED_ARGMAX_EN
        ,
        .class_idx(class_idx),
        .class_vld(class_vld)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_req && rd_gnt) begin
            act_data <= act_mem[act_addr];
            wgt_data <= wgt_mem[wgt_addr];
        end
        if (bias_rd) bias_data <= bias_mem[bias_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] golden(input int k);
        logic [31:0]        a;
        logic signed [39:0] p;
        a = bias_mem[k];
        for (int i = 0; i < 128; i++) begin
            p = act_mem[i] * wgt_mem[k*128+i];
            a = a + p[31:0];
        end
        return a;
    endfunction

    task automatic load_ones();
        for (int i = 0; i < 128; i++) act_mem[i] = 32'sd1;
        for (int i = 0; i < 1280; i++) wgt_mem[i] = 8'sd1;
        for (int k = 0; k < 10; k++) bias_mem[k] = k;
    endtask

    task automatic run_layer(input int gnt_pct, input int stop_at, input bit pulse);
        bit          prev_stall = 1'b0;
        logic [6:0]  pa = '0;
        logic [10:0] pw = '0;
        cyc = 0; we_cnt = 0; done_cnt = 0; stall_cnt = 0; stall_err = 0; done_cyc = -1;
        for (int k = 0; k < 10; k++) begin cap[k] = 'x; we_cyc[k] = -1; end
        @(negedge clk);
        start = 1'b1;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (prev_stall && rd_req && (act_addr !== pa || wgt_addr !== pw)) stall_err++;
            if (out_we) begin
                cap[out_addr] = out_data;
                we_cyc[out_addr] = cyc;
                we_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            rd_gnt = ($urandom_range(99) < gnt_pct);
            if (rd_req && !rd_gnt) stall_cnt++;
            prev_stall = rd_req && !rd_gnt;
            pa = act_addr;
            pw = wgt_addr;
            if (pulse && (cyc == 300 || cyc == 700 || done)) start = 1'b1;
            if (done || cyc == stop_at) break;
        end
    endtask

    task automatic watch(input int n, output int we, output int dn);
        we = 0; dn = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_we) we++;
            if (done) dn++;
        end
    endtask

    initial begin
        load_ones();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_strobes", {29'd0, rd_req, bias_rd, out_we}, 0);
        chk("rst_addrs", {14'd0, act_addr, wgt_addr}, 0);
        chk("rst_out", {out_addr, bias_addr, 24'd0}, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b1;

        run_layer(100, 0, 0);
        chk("t1_done_cyc", done_cyc, 1311);
        chk("t1_we_cnt", we_cnt, 10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t1_out%0d", k), cap[k], 32'(128 + k));
            chk($sformatf("t1_we_cyc%0d", k), we_cyc[k], 32'(131 * (k + 1)));
        end
        watch(5, w_we, w_dn);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_strobes", w_we + w_dn, 0);

        for (int i = 0; i < 128; i++) act_mem[i] = $urandom;
        for (int i = 0; i < 1280; i++) wgt_mem[i] = 8'($urandom);
        for (int k = 0; k < 10; k++) bias_mem[k] = $urandom;
        run_layer(50, 0, 0);
        for (int k = 0; k < 10; k++) chk($sformatf("t2_out%0d", k), cap[k], golden(k));
        chk("t2_stall_addr", stall_err, 0);
        chk("t2_done_cyc", done_cyc, 1311 + stall_cnt);
        chk("t2_we_cnt", we_cnt, 10);

        for (int i = 0; i < 128; i++) act_mem[i] = 32'h7FFFFFFF;
        for (int i = 0; i < 1280; i++) wgt_mem[i] = 8'sd127;
        for (int k = 0; k < 10; k++) bias_mem[k] = 0;
        run_layer(100, 0, 0);
        for (int k = 0; k < 10; k++) chk($sformatf("t3_ovf%0d", k), cap[k], 32'hFFFFC080);

        load_ones();
        run_layer(100, 0, 1);
        chk("t4_done_cyc", done_cyc, 1311);
        chk("t4_we_cnt", we_cnt, 10);
        chk("t4_out9", cap[9], 32'd137);
        @(negedge clk);
        start = 1'b0;
        watch(10, w_we, w_dn);
        chk("t4_no_restart", {30'd0, busy, w_we != 0 || w_dn != 0}, 0);

        run_layer(100, 574, 0);
        chk("t5_busy_mid", 32'(busy), 1);
        chk("t5_we_before", we_cnt, 4);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_req", 32'(rd_req), 0);
        reset = 1'b1;
        watch(200, w_we, w_dn);
        chk("t5_quiet", w_we + w_dn, 0);
        chk("t5_idle_busy", 32'(busy), 0);
        run_layer(100, 0, 0);
        chk("t5_done_cyc", done_cyc, 1311);
        chk("t5_out0", cap[0], 32'd128);
        chk("t5_out4", cap[4], 32'd132);
        chk("t5_out9", cap[9], 32'd137);

`ifdef FC_SCHED_ARGMAX_EN
        for (int i = 0; i < 128; i++) act_mem[i] = 0;
        bias_mem[0] = 5;   bias_mem[1] = -3;  bias_mem[2] = 2;  bias_mem[3] = 100;
        bias_mem[4] = 7;   bias_mem[5] = -50; bias_mem[6] = 0;  bias_mem[7] = 100;
        bias_mem[8] = 99;  bias_mem[9] = -1;
        run_layer(100, 0, 0);
        chk("t6_class_vld", 32'(class_vld), 1);
        chk("t6_class_idx", 32'(class_idx), 3);
        chk("t6_out7", cap[7], 32'd100);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fc_layer_sched.md
Name: fc_layer_sched

Overview:
- Sequential scheduler for a fully connected layer; replaces the single-cycle 128-wide dot product with one shared MAC time-multiplexed over all neurons.
- Fetches activations and int8 weights from synchronous memories through a request/grant port, accumulates each neuron from its bias, and writes one 32-bit result per neuron into the output buffer.
- Sits between the fc1 activation buffer, the weight/bias ROMs and the classifier output stage.

Parameters:
- N_IN, 128, inputs per neuron (activation count)
- N_OUT, 10, neurons (output count)
- W_AW, 11, weight address width (ceil log2(N_IN*N_OUT))

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at layer completion
- rd_req  out  1  activation+weight read request
- rd_gnt  in  1  grant; read occurs when rd_req && rd_gnt
- act_addr  out  7  activation index i
- wgt_addr  out  W_AW  ind*N_IN + i
- act_data  in  32 signed  valid the cycle after a granted read
- wgt_data  in  8 signed  valid the cycle after a granted read
- bias_rd  out  1  bias read strobe, no grant
- bias_addr  out  4  neuron index
- bias_data  in  32 signed  valid the cycle after bias_rd
- out_we  out  1  output write strobe
- out_addr  out  4  neuron index
- out_data  out  32 signed  neuron result

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; ind, i, acc cleared; all outputs 0. Applies mid-layer: operation is abandoned, no further out_we, no done.
- States: IDLE, BIAS, ISSUE, DRAIN, WRITE, DONE.
- IDLE: start==1 -> BIAS with ind=0. Start in any other state is ignored.
- BIAS (1 cycle): bias_rd=1, bias_addr=ind; i<=0 -> ISSUE.
- ISSUE: first cycle loads acc<=bias_data, unconditionally, including when gnt=0. rd_req=1, addresses driven from i. i increments only on a granted read. Granted read with i==N_IN-1 -> DRAIN.
- Response pipeline: vld_d is a registered copy of (rd_req && rd_gnt). When vld_d=1, acc <= acc + act_data*wgt_data. The 40-bit product is truncated to 32 bits; acc wraps two's complement with no saturation. In the first ISSUE cycle vld_d is 0 by construction.
- DRAIN (1 cycle): rd_req=0; the last product accumulates -> WRITE.
- WRITE (1 cycle): out_we=1, out_addr=ind, out_data=acc. If ind==N_OUT-1 -> DONE, else ind++ -> BIAS.
- DONE (1 cycle): done=1 -> IDLE. busy=0 in IDLE.
- Latency with rd_gnt held at 1: start sampled at cycle 0; neuron k written at cycle 131*(k+1); done at cycle 1311. Each grant-low cycle in ISSUE adds exactly one cycle.
- rd_req stays asserted with stable addresses while rd_gnt=0.
- ind never exceeds N_OUT-1; i never exceeds N_IN-1. There is no wrap within a layer.

Optional Feature:
- Macro: FC_SCHED_ARGMAX_EN.
- Defined: adds output ports class_idx (4 bit) and class_vld (1 bit). A running max is compared at each WRITE using a signed compare. Ties keep the lowest index. class_idx becomes valid with class_vld=1 in the DONE cycle and holds until the next accepted start. Both are reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package fc_pkg: state enum sched_state_t; N_IN/N_OUT defaults; ACC_W=32, ACT_W=32, WGT_W=8 constants.
- One sub-module, fc_mac: registered vld_d, truncating multiply-accumulate with load-bias control. The FSM stays in fc_layer_sched.

Test Plan:
- Reset, then start; all acts=1, all weights=1, biases=0..9, gnt=1 -> out_data[k]=128+k; out_we at cycles 131(k+1); done at 1311.
- Random int8 weights, random signed acts, random biases; gnt random 50% -> outputs match golden 32-bit wrapped dot product; rd_req addresses stable while gnt=0.
- Overflow: acts=32'h7FFFFFFF, weights=127, bias=0 -> out_data equals truncated 32-bit wrapped sum.
- Start pulsed mid-layer and during DONE -> ignored; exactly 10 out_we and 1 done per layer.
- reset=0 asserted during neuron 4 ISSUE -> next cycle IDLE, busy=0, no further out_we or done; a subsequent start completes a full layer correctly.
- FC_SCHED_ARGMAX_EN: outputs with ties at indices 3 and 7 as the max -> class_idx=3, class_vld=1 at the done cycle.
